// File: rtl/bitfusion_pkg.sv
// rtl/bitfusion_pkg.sv - shared types and helpers for the bitbrick sequencer
package bitfusion_pkg;

  typedef enum logic [1:0] {
    PREC2 = 2'b00,
    PREC4 = 2'b01,
    PREC8 = 2'b10
  } prec_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  localparam int BB_W      = 2;
  localparam int BB_PROD_W = 10;
  localparam int BB_SIG_W  = 6;

  // The reserved code 2'b11 behaves as full 8-bit precision.
  function automatic prec_e prec_decode(logic [1:0] code);
    case (code)
      2'b00:   return PREC2;
      2'b01:   return PREC4;
      default: return PREC8;
    endcase
  endfunction

  function automatic logic [2:0] slices_of(prec_e p);
    case (p)
      PREC2:   return 3'd1;
      PREC4:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/bitbrick_sequencer_slice_mux.sv
// rtl/bitbrick_sequencer_slice_mux.sv - selects the current A/B slice pair and their sign flags
module bb_slice_mux
  import bitfusion_pkg::*;
#(
  parameter int OPW = 8,
  parameter int IW  = 2
) (
  input  logic [OPW-1:0]  a_r,
  input  logic [OPW-1:0]  b_r,
  input  logic [IW-1:0]   i,
  input  logic [IW-1:0]   j,
  input  logic [IW:0]     n,
  input  logic            a_signed,
  input  logic            b_signed,
  output logic [BB_W-1:0] bb_x,
  output logic            bb_sx,
  output logic [BB_W-1:0] bb_y,
  output logic            bb_sy
);

  logic [IW:0] top_idx;

  assign top_idx = n - 1'b1;

  // Only the most significant slice of a signed operand is treated as signed.
  always_comb begin
    bb_x  = a_r[{i, 1'b0} +: BB_W];
    bb_y  = b_r[{j, 1'b0} +: BB_W];
    bb_sx = a_signed && ({1'b0, i} == top_idx);
    bb_sy = b_signed && ({1'b0, j} == top_idx);
  end

endmodule

// File: rtl/bitbrick_sequencer.sv
// rtl/bitbrick_sequencer.sv - drives one 2-bit bitbrick over all slice pairs and accumulates the product
module bitbrick_sequencer
  import bitfusion_pkg::*;
#(
  parameter int OPW  = 8,
  parameter int RESW = 2 * OPW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPW-1:0]       a,
  input  logic [OPW-1:0]       b,
  input  logic                 a_signed,
  input  logic                 b_signed,
  input  logic [1:0]           prec,
  output logic [BB_W-1:0]      bb_x,
  output logic                 bb_sx,
  output logic [BB_W-1:0]      bb_y,
  output logic                 bb_sy,
  output logic [2:0]           bb_shift,
  input  logic [BB_PROD_W-1:0] bb_prod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RESW-1:0]      result
);

  localparam int IW = (OPW / 2 > 1) ? $clog2(OPW / 2) : 1;

  state_e          state, state_nxt;
  logic [OPW-1:0]  a_r, b_r;
  logic            as_r, bs_r;
  logic [IW:0]     n_r;
  logic [IW-1:0]   i_r, j_r;
  logic [RESW-1:0] acc, acc_nxt, result_r, pp;
  logic [IW+1:0]   shamt;
  logic            last_i, last_j, run_en;
  logic [BB_W-1:0] mx_x, mx_y;
  logic            mx_sx, mx_sy;
  logic            unused_prod;

  bb_slice_mux #(.OPW(OPW), .IW(IW)) u_mux (
    .a_r      (a_r),
    .b_r      (b_r),
    .i        (i_r),
    .j        (j_r),
    .n        (n_r),
    .a_signed (as_r),
    .b_signed (bs_r),
    .bb_x     (mx_x),
    .bb_sx    (mx_sx),
    .bb_y     (mx_y),
    .bb_sy    (mx_sy)
  );

  assign last_i = ({1'b0, i_r} == n_r - 1'b1);
  assign last_j = ({1'b0, j_r} == n_r - 1'b1);

  // Alignment reaches 12 bits, beyond the bitbrick's shift range, so it is applied here.
  assign pp          = {{(RESW-BB_SIG_W){bb_prod[BB_SIG_W-1]}}, bb_prod[BB_SIG_W-1:0]};
  assign shamt       = {({1'b0, i_r} + {1'b0, j_r}), 1'b0};
  assign acc_nxt     = acc + (pp << shamt);
  assign unused_prod = ^bb_prod[BB_PROD_W-1:BB_SIG_W];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    run_en    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        run_en = ~rst;
        if (last_i && last_j) state_nxt = DONE;
      end
      DONE: begin
        out_valid = ~rst;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bb_x     = run_en ? mx_x : '0;
  assign bb_y     = run_en ? mx_y : '0;
  assign bb_sx    = run_en & mx_sx;
  assign bb_sy    = run_en & mx_sy;
  assign bb_shift = 3'd0;
  assign result   = rst ? '0 : result_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      i_r      <= '0;
      j_r      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      as_r     <= 1'b0;
      bs_r     <= 1'b0;
      n_r      <= '0;
      result_r <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          a_r  <= a;
          b_r  <= b;
          as_r <= a_signed;
          bs_r <= b_signed;
          n_r  <= (IW+1)'(slices_of(prec_decode(prec)));
          acc  <= '0;
          i_r  <= '0;
          j_r  <= '0;
        end
        RUN: begin
          acc <= acc_nxt;
          if (last_j) begin
            j_r <= '0;
            i_r <= i_r + 1'b1;
          end else begin
            j_r <= j_r + 1'b1;
          end
          if (last_i && last_j) result_r <= acc_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/bitbrick_sequencer.md
Name: bitbrick_sequencer

Overview:
Temporal controller for one 2-bit bitbrick multiplier, acting as the driving end of the bitbrick port (x/s_x/y/s_y/shift in, prod out). It accepts one multiply job (2-, 4- or 8-bit operands, each independently signed or unsigned) over a valid/ready handshake. It decomposes each operand into 2-bit slices and issues every slice pair to the external bitbrick, one pair per cycle. It sign-extends and aligns each partial product, accumulates them, and returns the 16-bit product over a second valid/ready handshake.

Parameters:
OPW, 8, maximum operand width in bits; must be even; slices per operand = OPW/2
RESW, 16, result width (2*OPW)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  job offered
in_ready  out  1  sequencer can accept a job
a  in  OPW  operand A; only the low P bits are used
b  in  OPW  operand B; only the low P bits are used
a_signed  in  1  A is two's complement
b_signed  in  1  B is two's complement
prec  in  2  00 = 2-bit, 01 = 4-bit, 10 = 8-bit, 11 = reserved (treated as 8-bit)
bb_x  out  2  A slice to bitbrick
bb_sx  out  1  A slice is the signed top slice
bb_y  out  2  B slice to bitbrick
bb_sy  out  1  B slice is the signed top slice
bb_shift  out  3  bitbrick shift; always 3'd0
bb_prod  in  10  bitbrick product (combinational from bb_* outputs)
out_valid  out  1  result available
out_ready  in  1  consumer takes result
result  out  RESW  signed/unsigned product, sign- or zero-extended to RESW

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- State on reset: IDLE; acc = 0, i = j = 0.
- Outputs during reset: out_valid = 0, result = 0, bb_x/bb_sx/bb_y/bb_sy = 0, bb_shift = 0, in_ready = 0.
- Reset mid-operation: rst asserted in any state drops the job; the cycle after rst deasserts, the block is in IDLE with in_ready = 1 and emits no result.
- N = slices per operand = P/2, where P = 2, 4 or 8 from prec.
- IDLE:
  - in_ready = 1; bb_* = 0.
  - On in_valid: register a, b, signedness and prec; clear acc; set i = j = 0; go to RUN.
- RUN: i indexes the A slice and j indexes the B slice.
  - bb_x = a_r[2i+1:2i] and bb_y = b_r[2j+1:2j].
  - bb_sx = a_signed_r AND (i == N-1); bb_sy = b_signed_r AND (j == N-1).
  - Each cycle: acc += sext16(bb_prod[5:0]) << 2(i+j).
  - Step order: j increments first; on j == N-1, j wraps to 0 and i increments.
  - At i == j == N-1, the final add happens and the state goes to DONE.
  - RUN lasts exactly N*N cycles: 1, 4 or 16.
  - in_ready = 0; in_valid is ignored.
- Alignment: partial-product alignment is done in the accumulator because the maximum alignment (12) exceeds the bitbrick's 3-bit shift range. bb_shift is therefore tied 0.
- Accumulator arithmetic: acc is RESW bits, two's complement, and wraps modulo 2^RESW.
  - No overflow is possible for legal inputs.
  - Unsigned 8x8 stays below 2^16; the most negative signed case, -128 * 127 = -16256, fits.
- DONE:
  - out_valid = 1; result = acc, held stable until out_ready.
  - On out_valid AND out_ready, go to IDLE; out_valid = 0 the next cycle.
  - in_ready = 0 while in DONE; there is no overlap of jobs.
- result is registered. It holds the last value after handshake until the next DONE; it is 0 only after reset.
- Latency: job accepted at edge T; RUN occupies T+1 .. T+N²; out_valid is high from T+N²+1.
- Throughput: one job per N²+2 cycles when out_ready is held high.
- Lower precisions: upper operand bits are ignored. The 2-bit case uses slice 0 only, and slice 0 is the signed slice.
- Mixed signedness is legal; each operand's top slice carries its own sign flag.

Decomposition:
- Shared package bitfusion_pkg:
  - prec_e enum (PREC2/PREC4/PREC8), with the reserved code mapped to PREC8.
  - constants BB_W = 2, BB_PROD_W = 10, BB_SIG_W = 6.
  - state_e enum (IDLE, RUN, DONE).
  - function slices_of(prec_e).
- One sub-module: bb_slice_mux. It is combinational and takes a_r, b_r, i, j, N and signedness, producing bb_x, bb_sx, bb_y and bb_sy.
- The FSM and accumulator stay in the top module. The bench pairs the top with the real bitbrick.

Test Plan:
- prec=10, unsigned, a=0xFF, b=0xFF -> result 0xFE01; 16 RUN cycles; out_valid exactly at T+17.
- prec=10, both signed: a=0x80, b=0x80 -> 0x4000; a=0x80, b=0x7F -> 0xC080.
- prec=10, a signed 0xFF, b unsigned 0xFF -> 0xFF01 (-255). Covers mixed signedness; bb_sx high only when i=3, bb_sy never high.
- prec=01, signed, a=0xF8 (upper nibble ignored, -8), b=0x07 -> 0xFFC8 after 4 RUN cycles. prec=00: signed 2'b10 * 2'b11 -> 0x0002; unsigned 3*3 -> 0x0009 after 1 RUN cycle.
- Backpressure: out_ready held low 5 cycles in DONE -> result and out_valid stable, in_ready = 0, a concurrent in_valid is not accepted; after out_ready, IDLE, and the next job is accepted.
- Reset mid-job: rst pulsed in RUN cycle 7 of 16 -> next cycle IDLE, out_valid = 0, acc = 0, no result emitted. A following 0x03 * 0x05 unsigned job returns 0x000F.
